// File: rtl/tl_client_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// tl_client_arbiter_2to1
//   Shares one downstream TileLink-UL port (A request, D response) between
//   two upstream clients.
//   - A channel: round-robin grant, held for a whole multi-beat message.
//   - The downstream source ID is {client index, client source}.
//   - D beats are steered back by the source MSB, which is stripped on return.
//
// Ports
//   clock, reset          single clock; asynchronous active-high reset
//   inN_a_*  (N = 0,1)    client A request (valid/ready + bits)
//   inN_d_*               client D response (valid/ready + bits)
//   out_a_*               downstream A request, source is SRC_W+1 bits
//   out_d_*               downstream D response, source is SRC_W+1 bits
//   perf_msgs0/1, perf_stall   32-bit counters, present only when
//                              TL_ARB_PERF_EN is defined
//
// Optional build macro: TL_ARB_PERF_EN
// ---------------------------------------------------------------------------
module tl_client_arbiter_2to1 #(
    parameter int unsigned SRC_W  = 7,
    parameter int unsigned ADDR_W = 29,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    // client 0, A channel
    input  logic                in0_a_valid,
    output logic                in0_a_ready,
    input  logic [2:0]          in0_a_bits_opcode,
    input  logic [2:0]          in0_a_bits_param,
    input  logic [3:0]          in0_a_bits_size,
    input  logic [SRC_W-1:0]    in0_a_bits_source,
    input  logic [ADDR_W-1:0]   in0_a_bits_address,
    input  logic [DATA_W/8-1:0] in0_a_bits_mask,
    input  logic [DATA_W-1:0]   in0_a_bits_data,
    input  logic                in0_a_bits_corrupt,
    // client 0, D channel
    output logic                in0_d_valid,
    input  logic                in0_d_ready,
    output logic [2:0]          in0_d_bits_opcode,
    output logic [1:0]          in0_d_bits_param,
    output logic [3:0]          in0_d_bits_size,
    output logic [SRC_W-1:0]    in0_d_bits_source,
    output logic                in0_d_bits_sink,
    output logic                in0_d_bits_denied,
    output logic [DATA_W-1:0]   in0_d_bits_data,
    output logic                in0_d_bits_corrupt,
    // client 1, A channel
    input  logic                in1_a_valid,
    output logic                in1_a_ready,
    input  logic [2:0]          in1_a_bits_opcode,
    input  logic [2:0]          in1_a_bits_param,
    input  logic [3:0]          in1_a_bits_size,
    input  logic [SRC_W-1:0]    in1_a_bits_source,
    input  logic [ADDR_W-1:0]   in1_a_bits_address,
    input  logic [DATA_W/8-1:0] in1_a_bits_mask,
    input  logic [DATA_W-1:0]   in1_a_bits_data,
    input  logic                in1_a_bits_corrupt,
    // client 1, D channel
    output logic                in1_d_valid,
    input  logic                in1_d_ready,
    output logic [2:0]          in1_d_bits_opcode,
    output logic [1:0]          in1_d_bits_param,
    output logic [3:0]          in1_d_bits_size,
    output logic [SRC_W-1:0]    in1_d_bits_source,
    output logic                in1_d_bits_sink,
    output logic                in1_d_bits_denied,
    output logic [DATA_W-1:0]   in1_d_bits_data,
    output logic                in1_d_bits_corrupt,
    // downstream A channel
    output logic                out_a_valid,
    input  logic                out_a_ready,
    output logic [2:0]          out_a_bits_opcode,
    output logic [2:0]          out_a_bits_param,
    output logic [3:0]          out_a_bits_size,
    output logic [SRC_W:0]      out_a_bits_source,
    output logic [ADDR_W-1:0]   out_a_bits_address,
    output logic [DATA_W/8-1:0] out_a_bits_mask,
    output logic [DATA_W-1:0]   out_a_bits_data,
    output logic                out_a_bits_corrupt,
    // downstream D channel
    input  logic                out_d_valid,
    output logic                out_d_ready,
    input  logic [2:0]          out_d_bits_opcode,
    input  logic [1:0]          out_d_bits_param,
    input  logic [3:0]          out_d_bits_size,
    input  logic [SRC_W:0]      out_d_bits_source,
    input  logic                out_d_bits_sink,
    input  logic                out_d_bits_denied,
    input  logic [DATA_W-1:0]   out_d_bits_data,
    input  logic                out_d_bits_corrupt
`ifdef TL_ARB_PERF_EN
    ,
    output logic [31:0]         perf_msgs0,
    output logic [31:0]         perf_msgs1,
    output logic [31:0]         perf_stall
`endif
);

    localparam int unsigned LG_BEAT = $clog2(DATA_W / 8);
    localparam int unsigned BEATS_W = 12 - LG_BEAT;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        BURST
    } state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q,  last_d;
    logic [BEATS_W-1:0] beats_q, beats_d;

    logic               sel;
    logic               a_valid;
    logic               a_fire;
    logic [BEATS_W-1:0] first_rem;
    logic               d_idx;

    // In IDLE the grant is combinational (zero-cycle latency); in HOLD and
    // BURST the latched grant is forwarded unchanged.
    always_comb begin
        sel = grant_q;
        if (state_q == IDLE) begin
            if (in0_a_valid && in1_a_valid) sel = ~last_q;
            else if (in0_a_valid)           sel = 1'b0;
            else if (in1_a_valid)           sel = 1'b1;
            else                            sel = ~last_q;
        end
    end

    assign a_valid = !reset && (sel ? in1_a_valid : in0_a_valid);
    assign a_fire  = a_valid && out_a_ready;

    assign out_a_valid        = a_valid;
    assign out_a_bits_opcode  = sel ? in1_a_bits_opcode  : in0_a_bits_opcode;
    assign out_a_bits_param   = sel ? in1_a_bits_param   : in0_a_bits_param;
    assign out_a_bits_size    = sel ? in1_a_bits_size    : in0_a_bits_size;
    assign out_a_bits_source  = {sel, sel ? in1_a_bits_source : in0_a_bits_source};
    assign out_a_bits_address = sel ? in1_a_bits_address : in0_a_bits_address;
    assign out_a_bits_mask    = sel ? in1_a_bits_mask    : in0_a_bits_mask;
    assign out_a_bits_data    = sel ? in1_a_bits_data    : in0_a_bits_data;
    assign out_a_bits_corrupt = sel ? in1_a_bits_corrupt : in0_a_bits_corrupt;

    assign in0_a_ready = !reset && !sel && out_a_ready;
    assign in1_a_ready = !reset &&  sel && out_a_ready;

    // Beats remaining after the first beat of a message: only Put messages
    // wider than one beat carry data over several beats.
    always_comb begin
        first_rem = '0;
        if ((out_a_bits_opcode == 3'd0 || out_a_bits_opcode == 3'd1) &&
            ({28'd0, out_a_bits_size} > 32'(LG_BEAT))) begin
            first_rem = BEATS_W'((32'd1 << ({28'd0, out_a_bits_size} - 32'(LG_BEAT))) - 32'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beats_d = beats_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (a_fire) begin
                    grant_d = sel;
                    if (first_rem == '0) begin
                        state_d = IDLE;
                        last_d  = sel;
                    end else begin
                        state_d = BURST;
                        beats_d = first_rem;
                    end
                end else if (a_valid) begin
                    state_d = HOLD;
                    grant_d = sel;
                end else begin
                    // a stalled client withdrawing valid releases the grant
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (a_fire) begin
                    beats_d = beats_q - BEATS_W'(1);
                    if (beats_q == BEATS_W'(1)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

    // D channel: purely combinational steering on the source MSB.
    assign d_idx       = out_d_bits_source[SRC_W];
    assign in0_d_valid = !reset && out_d_valid && !d_idx;
    assign in1_d_valid = !reset && out_d_valid &&  d_idx;
    assign out_d_ready = !reset && (d_idx ? in1_d_ready : in0_d_ready);

    assign in0_d_bits_opcode  = out_d_bits_opcode;
    assign in0_d_bits_param   = out_d_bits_param;
    assign in0_d_bits_size    = out_d_bits_size;
    assign in0_d_bits_source  = out_d_bits_source[SRC_W-1:0];
    assign in0_d_bits_sink    = out_d_bits_sink;
    assign in0_d_bits_denied  = out_d_bits_denied;
    assign in0_d_bits_data    = out_d_bits_data;
    assign in0_d_bits_corrupt = out_d_bits_corrupt;

    assign in1_d_bits_opcode  = out_d_bits_opcode;
    assign in1_d_bits_param   = out_d_bits_param;
    assign in1_d_bits_size    = out_d_bits_size;
    assign in1_d_bits_source  = out_d_bits_source[SRC_W-1:0];
    assign in1_d_bits_sink    = out_d_bits_sink;
    assign in1_d_bits_denied  = out_d_bits_denied;
    assign in1_d_bits_data    = out_d_bits_data;
    assign in1_d_bits_corrupt = out_d_bits_corrupt;

`ifdef TL_ARB_PERF_EN
    logic        msg_done;
    logic [31:0] msgs0_q, msgs1_q, stall_q;

    // a message completes when its final beat fires
    assign msg_done = a_fire &&
                      ((state_q != BURST && first_rem == '0) ||
                       (state_q == BURST && beats_q == BEATS_W'(1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            msgs0_q <= '0;
            msgs1_q <= '0;
            stall_q <= '0;
        end else begin
            if (msg_done && !sel)             msgs0_q <= msgs0_q + 32'd1;
            if (msg_done &&  sel)             msgs1_q <= msgs1_q + 32'd1;
            if (a_valid && !out_a_ready)      stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_msgs0 = msgs0_q;
    assign perf_msgs1 = msgs1_q;
    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_tl_client_arbiter_2to1.sv
module tb_tl_client_arbiter_2to1;

    localparam int SRC_W  = 7;
    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic              in0_a_valid, in0_a_ready, in0_a_bits_corrupt;
    logic [2:0]        in0_a_bits_opcode, in0_a_bits_param;
    logic [3:0]        in0_a_bits_size;
    logic [6:0]        in0_a_bits_source;
    logic [28:0]       in0_a_bits_address;
    logic [7:0]        in0_a_bits_mask;
    logic [63:0]       in0_a_bits_data;
    logic              in0_d_valid, in0_d_ready, in0_d_bits_sink, in0_d_bits_denied, in0_d_bits_corrupt;
    logic [2:0]        in0_d_bits_opcode;
    logic [1:0]        in0_d_bits_param;
    logic [3:0]        in0_d_bits_size;
    logic [6:0]        in0_d_bits_source;
    logic [63:0]       in0_d_bits_data;

    logic              in1_a_valid, in1_a_ready, in1_a_bits_corrupt;
    logic [2:0]        in1_a_bits_opcode, in1_a_bits_param;
    logic [3:0]        in1_a_bits_size;
    logic [6:0]        in1_a_bits_source;
    logic [28:0]       in1_a_bits_address;
    logic [7:0]        in1_a_bits_mask;
    logic [63:0]       in1_a_bits_data;
    logic              in1_d_valid, in1_d_ready, in1_d_bits_sink, in1_d_bits_denied, in1_d_bits_corrupt;
    logic [2:0]        in1_d_bits_opcode;
    logic [1:0]        in1_d_bits_param;
    logic [3:0]        in1_d_bits_size;
    logic [6:0]        in1_d_bits_source;
    logic [63:0]       in1_d_bits_data;

    logic              out_a_valid, out_a_ready, out_a_bits_corrupt;
    logic [2:0]        out_a_bits_opcode, out_a_bits_param;
    logic [3:0]        out_a_bits_size;
    logic [7:0]        out_a_bits_source;
    logic [28:0]       out_a_bits_address;
    logic [7:0]        out_a_bits_mask;
    logic [63:0]       out_a_bits_data;
    logic              out_d_valid, out_d_ready, out_d_bits_sink, out_d_bits_denied, out_d_bits_corrupt;
    logic [2:0]        out_d_bits_opcode;
    logic [1:0]        out_d_bits_param;
    logic [3:0]        out_d_bits_size;
    logic [7:0]        out_d_bits_source;
    logic [63:0]       out_d_bits_data;
`ifdef TL_ARB_PERF_EN
    logic [31:0]       perf_msgs0, perf_msgs1, perf_stall;
`endif

    tl_client_arbiter_2to1 #(.SRC_W(SRC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready),
        .in0_a_bits_opcode(in0_a_bits_opcode), .in0_a_bits_param(in0_a_bits_param),
        .in0_a_bits_size(in0_a_bits_size), .in0_a_bits_source(in0_a_bits_source),
        .in0_a_bits_address(in0_a_bits_address), .in0_a_bits_mask(in0_a_bits_mask),
        .in0_a_bits_data(in0_a_bits_data), .in0_a_bits_corrupt(in0_a_bits_corrupt),
        .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready),
        .in0_d_bits_opcode(in0_d_bits_opcode), .in0_d_bits_param(in0_d_bits_param),
        .in0_d_bits_size(in0_d_bits_size), .in0_d_bits_source(in0_d_bits_source),
        .in0_d_bits_sink(in0_d_bits_sink), .in0_d_bits_denied(in0_d_bits_denied),
        .in0_d_bits_data(in0_d_bits_data), .in0_d_bits_corrupt(in0_d_bits_corrupt),
        .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready),
        .in1_a_bits_opcode(in1_a_bits_opcode), .in1_a_bits_param(in1_a_bits_param),
        .in1_a_bits_size(in1_a_bits_size), .in1_a_bits_source(in1_a_bits_source),
        .in1_a_bits_address(in1_a_bits_address), .in1_a_bits_mask(in1_a_bits_mask),
        .in1_a_bits_data(in1_a_bits_data), .in1_a_bits_corrupt(in1_a_bits_corrupt),
        .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready),
        .in1_d_bits_opcode(in1_d_bits_opcode), .in1_d_bits_param(in1_d_bits_param),
        .in1_d_bits_size(in1_d_bits_size), .in1_d_bits_source(in1_d_bits_source),
        .in1_d_bits_sink(in1_d_bits_sink), .in1_d_bits_denied(in1_d_bits_denied),
        .in1_d_bits_data(in1_d_bits_data), .in1_d_bits_corrupt(in1_d_bits_corrupt),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_bits_opcode(out_a_bits_opcode), .out_a_bits_param(out_a_bits_param),
        .out_a_bits_size(out_a_bits_size), .out_a_bits_source(out_a_bits_source),
        .out_a_bits_address(out_a_bits_address), .out_a_bits_mask(out_a_bits_mask),
        .out_a_bits_data(out_a_bits_data), .out_a_bits_corrupt(out_a_bits_corrupt),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_bits_opcode(out_d_bits_opcode), .out_d_bits_param(out_d_bits_param),
        .out_d_bits_size(out_d_bits_size), .out_d_bits_source(out_d_bits_source),
        .out_d_bits_sink(out_d_bits_sink), .out_d_bits_denied(out_d_bits_denied),
        .out_d_bits_data(out_d_bits_data), .out_d_bits_corrupt(out_d_bits_corrupt)
`ifdef TL_ARB_PERF_EN
        , .perf_msgs0(perf_msgs0), .perf_msgs1(perf_msgs1), .perf_stall(perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [6:0]  src;
        logic [28:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        int          beats;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    // Number of beats in a message: multi-beat only for Puts wider than 8 bytes.
    function automatic int msg_beats(input logic [2:0] op, input logic [3:0] size);
        if (op <= 3'd1 && size > 4'd3) return 1 << (int'(size) - 3);
        return 1;
    endfunction

    function automatic beat_t mk(input logic [2:0] op, input logic [3:0] size,
                                 input logic [6:0] src, input logic [63:0] data);
        beat_t b;
        b.op = op; b.size = size; b.src = src; b.addr = 29'h0000_1000;
        b.mask = 8'hFF; b.data = data; b.beats = msg_beats(op, size);
        return b;
    endfunction

    task automatic drive0(input logic v, input beat_t b);
        in0_a_valid = v; in0_a_bits_opcode = b.op; in0_a_bits_param = 3'd0;
        in0_a_bits_size = b.size; in0_a_bits_source = b.src; in0_a_bits_address = b.addr;
        in0_a_bits_mask = b.mask; in0_a_bits_data = b.data; in0_a_bits_corrupt = 1'b0;
    endtask

    task automatic drive1(input logic v, input beat_t b);
        in1_a_valid = v; in1_a_bits_opcode = b.op; in1_a_bits_param = 3'd0;
        in1_a_bits_size = b.size; in1_a_bits_source = b.src; in1_a_bits_address = b.addr;
        in1_a_bits_mask = b.mask; in1_a_bits_data = b.data; in1_a_bits_corrupt = 1'b0;
    endtask

    task automatic idle_inputs();
        drive0(1'b0, mk(3'd4, 4'd0, 7'd0, 64'd0));
        drive1(1'b0, mk(3'd4, 4'd0, 7'd0, 64'd0));
        out_a_ready = 1'b0; out_d_valid = 1'b0; in0_d_ready = 1'b0; in1_d_ready = 1'b0;
        out_d_bits_opcode = 3'd0; out_d_bits_param = 2'd0; out_d_bits_size = 4'd0;
        out_d_bits_source = 8'd0; out_d_bits_sink = 1'b0; out_d_bits_denied = 1'b0;
        out_d_bits_data = 64'd0; out_d_bits_corrupt = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic gen_msg(input int n);
        logic [2:0]  op;
        logic [3:0]  size;
        logic [6:0]  src;
        logic [28:0] addr;
        int          nb;
        beat_t       b;
        op   = ($urandom % 2 == 0) ? 3'd4 : (($urandom % 2 == 0) ? 3'd0 : 3'd1);
        size = 4'($urandom % 7);
        src  = 7'($urandom);
        addr = 29'($urandom);
        nb   = msg_beats(op, size);
        for (int i = 0; i < nb; i++) begin
            b.op = op; b.size = size; b.src = src; b.addr = addr;
            b.mask = 8'($urandom); b.data = {$urandom, $urandom}; b.beats = nb;
            if (n == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive0(1'b1, mk(3'd4, 4'd3, 7'h11, 64'd1));
        drive1(1'b1, mk(3'd4, 4'd3, 7'h22, 64'd2));
        out_a_ready = 1'b1; out_d_valid = 1'b1; in0_d_ready = 1'b1; in1_d_ready = 1'b1;
        out_d_bits_source = 8'h85;
        @(negedge clock);
        checks++;
        if ({out_a_valid, in0_a_ready, in1_a_ready, in0_d_valid, in1_d_valid, out_d_ready} !== 6'b0)
            begin errors++; $display("FAIL reset_outputs: got %b expected 000000",
                {out_a_valid, in0_a_ready, in1_a_ready, in0_d_valid, in1_d_valid, out_d_ready}); end
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({out_a_valid, out_a_bits_source, in0_a_ready, in1_a_ready} !== {1'b1, 8'h11, 1'b1, 1'b0})
            begin errors++; $display("FAIL reset_release_a: valid=%b src=%h rdy=%b%b expected 1 11 10",
                out_a_valid, out_a_bits_source, in0_a_ready, in1_a_ready); end
        checks++;
        if ({in1_d_valid, out_d_ready} !== 2'b11)
            begin errors++; $display("FAIL reset_release_d: got %b expected 11", {in1_d_valid, out_d_ready}); end
    endtask

    task automatic test_alternate();
        logic       g;
        logic [7:0] exp_src;
        do_reset();
        drive0(1'b1, mk(3'd4, 4'd3, 7'h11, 64'd0));
        drive1(1'b1, mk(3'd4, 4'd3, 7'h22, 64'd0));
        out_a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            g = (i % 2 == 1);
            exp_src = g ? 8'hA2 : 8'h11;
            checks++;
            if (out_a_valid !== 1'b1 || out_a_bits_source !== exp_src)
                begin errors++; $display("FAIL alternate_src[%0d]: valid=%b src=%h expected 1 %h",
                    i, out_a_valid, out_a_bits_source, exp_src); end
            checks++;
            if ({in1_a_ready, in0_a_ready} !== (g ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL alternate_ready[%0d]: got %b%b grant %0d",
                    i, in1_a_ready, in0_a_ready, g); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_burst();
        logic [63:0] d;
        do_reset();
        out_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 64'hA0 + 64'(i);
            drive0(1'b1, mk(3'd0, 4'd5, 7'h01, d));
            if (i >= 1) drive1(1'b1, mk(3'd4, 4'd3, 7'h02, 64'd0));
            @(negedge clock);
            checks++;
            if ({out_a_valid, out_a_bits_source, out_a_bits_data, in1_a_ready} !== {1'b1, 8'h01, d, 1'b0})
                begin errors++; $display("FAIL burst_beat[%0d]: valid=%b src=%h data=%h rdy1=%b expected 1 01 %h 0",
                    i, out_a_valid, out_a_bits_source, out_a_bits_data, in1_a_ready, d); end
            @(posedge clock); #1;
        end
        drive0(1'b0, mk(3'd4, 4'd0, 7'h00, 64'd0));
        @(negedge clock);
        checks++;
        if ({out_a_valid, out_a_bits_source, out_a_bits_opcode, in1_a_ready} !== {1'b1, 8'h82, 3'd4, 1'b1})
            begin errors++; $display("FAIL burst_then_get: valid=%b src=%h op=%0d rdy1=%b expected 1 82 4 1",
                out_a_valid, out_a_bits_source, out_a_bits_opcode, in1_a_ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_hold();
        do_reset();
        out_a_ready = 1'b1;
        drive0(1'b1, mk(3'd4, 4'd3, 7'h10, 64'd0));
        @(negedge clock);
        checks++;
        if (out_a_bits_source !== 8'h10)
            begin errors++; $display("FAIL hold_pre: src=%h expected 10", out_a_bits_source); end
        @(posedge clock); #1;
        // client 0 won last, so a fresh arbitration with both valid would pick client 1
        drive0(1'b1, mk(3'd4, 4'd3, 7'h11, 64'h5555));
        out_a_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) drive1(1'b1, mk(3'd4, 4'd3, 7'h21, 64'd0));
            @(negedge clock);
            checks++;
            if ({out_a_valid, out_a_bits_source, out_a_bits_data, in0_a_ready, in1_a_ready} !==
                {1'b1, 8'h11, 64'h5555, 1'b0, 1'b0})
                begin errors++; $display("FAIL hold_stall[%0d]: valid=%b src=%h data=%h rdy=%b%b expected 1 11 5555 00",
                    i, out_a_valid, out_a_bits_source, out_a_bits_data, in0_a_ready, in1_a_ready); end
            @(posedge clock); #1;
        end
        out_a_ready = 1'b1;
        @(negedge clock);
        checks++;
        if ({out_a_bits_source, in0_a_ready, in1_a_ready} !== {8'h11, 1'b1, 1'b0})
            begin errors++; $display("FAIL hold_fire: src=%h rdy=%b%b expected 11 10",
                out_a_bits_source, in0_a_ready, in1_a_ready); end
        @(posedge clock); #1;
        drive0(1'b0, mk(3'd4, 4'd0, 7'h00, 64'd0));
        @(negedge clock);
        checks++;
        if ({out_a_valid, out_a_bits_source} !== {1'b1, 8'hA1})
            begin errors++; $display("FAIL hold_after: valid=%b src=%h expected 1 a1", out_a_valid, out_a_bits_source); end
        @(posedge clock); #1;
    endtask

    task automatic test_d_route();
        do_reset();
        out_d_valid = 1'b1; out_d_bits_source = 8'h85; out_d_bits_data = 64'hDEAD_BEEF_0123_4567;
        in0_d_ready = 1'b1; in1_d_ready = 1'b1;
        @(negedge clock);
        checks++;
        if ({in1_d_valid, in1_d_bits_source, in0_d_valid, out_d_ready} !== {1'b1, 7'h05, 1'b0, 1'b1})
            begin errors++; $display("FAIL d_route: v1=%b src1=%h v0=%b rdy=%b expected 1 05 0 1",
                in1_d_valid, in1_d_bits_source, in0_d_valid, out_d_ready); end
        checks++;
        if (in1_d_bits_data !== 64'hDEAD_BEEF_0123_4567)
            begin errors++; $display("FAIL d_data: got %h expected deadbeef01234567", in1_d_bits_data); end
        in1_d_ready = 1'b0;
        #1;
        checks++;
        if (out_d_ready !== 1'b0)
            begin errors++; $display("FAIL d_backpressure: got %b expected 0", out_d_ready); end
        out_d_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_a_ready = 1'b1;
        drive0(1'b1, mk(3'd0, 4'd5, 7'h01, 64'h1));
        @(posedge clock); #1;
        drive0(1'b1, mk(3'd0, 4'd5, 7'h01, 64'h2));
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_a_valid, in0_a_ready, in1_a_ready} !== 3'b000)
            begin errors++; $display("FAIL midreset_outputs: got %b expected 000",
                {out_a_valid, in0_a_ready, in1_a_ready}); end
        @(posedge clock); #1 reset = 1'b0;
        drive0(1'b1, mk(3'd4, 4'd3, 7'h30, 64'd0));
        drive1(1'b1, mk(3'd4, 4'd3, 7'h31, 64'd0));
        @(negedge clock);
        checks++;
        if ({out_a_valid, out_a_bits_source} !== {1'b1, 8'h30})
            begin errors++; $display("FAIL midreset_first: valid=%b src=%h expected 1 30", out_a_valid, out_a_bits_source); end
        @(posedge clock); #1;
        drive0(1'b0, mk(3'd4, 4'd0, 7'h00, 64'd0));
        @(negedge clock);
        checks++;
        if ({out_a_valid, out_a_bits_source} !== {1'b1, 8'hB1})
            begin errors++; $display("FAIL midreset_idle: valid=%b src=%h expected 1 b1", out_a_valid, out_a_bits_source); end
        @(posedge clock); #1;
    endtask

    // Message-level model: an owner is locked from the first presented beat of
    // a message until its final beat fires; otherwise round-robin on valids.
    task automatic test_random();
        bit    held0, held1, v0, v1, g, ev, mlast, idx, exp_rdy;
        int    owner, rem;
        beat_t hb, junk;
        do_reset();
        q0.delete(); q1.delete();
        held0 = 0; held1 = 0; owner = -1; rem = 0; mlast = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (q0.size() == 0) gen_msg(0);
            if (q1.size() == 0) gen_msg(1);
            v0 = held0 || ($urandom % 2 == 0);
            v1 = held1 || ($urandom % 2 == 0);
            if (v0) held0 = 1;
            if (v1) held1 = 1;
            drive0(v0, q0[0]);
            drive1(v1, q1[0]);
            out_a_ready = ($urandom % 4 != 0);
            out_d_valid = 1'($urandom); out_d_bits_source = 8'($urandom);
            out_d_bits_data = {$urandom, $urandom}; out_d_bits_opcode = 3'($urandom);
            in0_d_ready = 1'($urandom); in1_d_ready = 1'($urandom);
            @(negedge clock);
            if (owner >= 0)    g = owner[0];
            else if (v0 && v1) g = ~mlast;
            else if (v0)       g = 1'b0;
            else if (v1)       g = 1'b1;
            else               g = ~mlast;
            ev = g ? v1 : v0;
            hb = g ? q1[0] : q0[0];
            checks++;
            if (out_a_valid !== ev)
                begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", cyc, out_a_valid, ev); end
            if (ev) begin
                checks++;
                if ({out_a_bits_source, out_a_bits_opcode, out_a_bits_size, out_a_bits_address,
                     out_a_bits_mask, out_a_bits_data} !== {g, hb.src, hb.op, hb.size, hb.addr, hb.mask, hb.data})
                    begin errors++; $display("FAIL rand_bits[%0d]: src=%h data=%h expected src=%h data=%h",
                        cyc, out_a_bits_source, out_a_bits_data, {g, hb.src}, hb.data); end
                checks++;
                if ({in1_a_ready, in0_a_ready} !== (g ? {out_a_ready, 1'b0} : {1'b0, out_a_ready}))
                    begin errors++; $display("FAIL rand_ready[%0d]: got %b%b grant %0d ready %b",
                        cyc, in1_a_ready, in0_a_ready, g, out_a_ready); end
            end
            idx = out_d_bits_source[7];
            exp_rdy = idx ? in1_d_ready : in0_d_ready;
            checks++;
            if ({in0_d_valid, in1_d_valid, out_d_ready, in0_d_bits_source, in1_d_bits_source, in0_d_bits_data} !==
                {out_d_valid & ~idx, out_d_valid & idx, exp_rdy, out_d_bits_source[6:0],
                 out_d_bits_source[6:0], out_d_bits_data})
                begin errors++; $display("FAIL rand_d[%0d]: v=%b%b rdy=%b src=%h expected v=%b%b rdy=%b",
                    cyc, in0_d_valid, in1_d_valid, out_d_ready, in0_d_bits_source,
                    out_d_valid & ~idx, out_d_valid & idx, exp_rdy); end
            if (ev) begin
                if (owner < 0) begin owner = int'(g); rem = hb.beats; end
                if (out_a_ready) begin
                    if (g) junk = q1.pop_front(); else junk = q0.pop_front();
                    rem--;
                    if (rem == 0) begin
                        owner = -1; mlast = g;
                        if (g) held1 = 0; else held0 = 0;
                    end
                end
            end
            @(posedge clock); #1;
        end
        idle_inputs();
    endtask

`ifdef TL_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        drive0(1'b1, mk(3'd4, 4'd3, 7'h01, 64'd0));
        out_a_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 out_a_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1 drive1(1'b1, mk(3'd4, 4'd3, 7'h02, 64'd0));
        repeat (10) @(posedge clock);
        #1 idle_inputs();
        @(negedge clock);
        checks++;
        if ({perf_msgs0, perf_msgs1, perf_stall} !== {32'd10, 32'd5, 32'd2})
            begin errors++; $display("FAIL perf_counters: got %0d %0d %0d expected 10 5 2",
                perf_msgs0, perf_msgs1, perf_stall); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_alternate();
        test_burst();
        test_hold();
        test_d_route();
        test_reset_mid_burst();
        test_random();
`ifdef TL_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
